// File: rtl/rotary_value_if.sv
// Detent/button pulses in, bounded setting and status out.
// The master drives the pulses and the slave (rotary_value) owns the setting.
interface rotary_value_if #(
    parameter int WIDTH = 16
);
    logic             cw;
    logic             ccw;
    logic             keyEdge;
    logic             clear;
    logic [WIDTH-1:0] value;
    logic [1:0]       stepSel;
    logic             changed;
    logic             atLimit;

    modport master (
        output cw, ccw, keyEdge, clear,
        input  value, stepSel, changed, atLimit
    );

    modport slave (
        input  cw, ccw, keyEdge, clear,
        output value, stepSel, changed, atLimit
    );
endinterface

// File: rtl/rotary_value.sv
// Bounded numeric setting driven by rotary detent pulses, with a selectable
// 1/10/100 step and a speed-based step multiplier for fast same-direction turning.
module rotary_value #(
    parameter int WIDTH     = 16,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 9999,
    parameter int WRAP      = 0,
    parameter int ACCEL_WIN = 2500000,
    parameter int ACCEL_MUL = 4
) (
    input  logic         clk,
    input  logic         rst,
    rotary_value_if.slave bus
);
    localparam int EW = WIDTH + 10;
    localparam int TW = $clog2(ACCEL_WIN + 1);

    localparam logic [EW-1:0]    MIN_E   = EW'(MIN_VAL);
    localparam logic [EW-1:0]    MAX_E   = EW'(MAX_VAL);
    localparam logic [EW-1:0]    RANGE_E = EW'(MAX_VAL - MIN_VAL + 1);
    localparam logic [EW-1:0]    MUL_E   = EW'(ACCEL_MUL);
    localparam logic [TW-1:0]    WIN_T   = TW'(ACCEL_WIN);
    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

    typedef enum logic [1:0] {DIR_NONE, DIR_CW, DIR_CCW} dir_e;

    logic [WIDTH-1:0] value_q, value_d;
    logic [1:0]       step_sel_q, step_sel_d;
    logic [1:0]       streak_q, streak_d;
    logic [TW-1:0]    timer_q, timer_d;
    dir_e             dir_q, dir_d;
    logic             changed_q, changed_d;

    logic             detent;
    dir_e             dir_now;
    logic [1:0]       streak_det;
    logic [EW-1:0]    base_e, step_e, cur_e, up_e, next_e;
    logic [WIDTH-1:0] next_w;

    assign detent  = bus.cw ^ bus.ccw;
    assign dir_now = bus.cw ? DIR_CW : DIR_CCW;

    // Streak as it would stand after this detent; the step multiplier keys off it.
    always_comb begin
        streak_det = 2'd0;
        if (dir_q == dir_now && timer_q < WIN_T)
            streak_det = (streak_q == 2'd3) ? 2'd3 : streak_q + 2'd1;
    end

    always_comb begin
        case (step_sel_q)
            2'd0:    base_e = EW'(1);
            2'd1:    base_e = EW'(10);
            default: base_e = EW'(100);
        endcase
    end

    assign step_e = (streak_det == 2'd3) ? base_e * MUL_E : base_e;
    assign cur_e  = EW'(value_q);
    assign up_e   = cur_e + step_e;

    // Wide arithmetic: compare before subtracting so the down path never underflows.
    always_comb begin
        next_e = cur_e;
        if (bus.cw) begin
            if (up_e > MAX_E)
                next_e = (WRAP != 0) ? up_e - RANGE_E : MAX_E;
            else
                next_e = up_e;
        end else begin
            if (cur_e < MIN_E + step_e)
                next_e = (WRAP != 0) ? cur_e + RANGE_E - step_e : MIN_E;
            else
                next_e = cur_e - step_e;
        end
    end

    assign next_w = next_e[WIDTH-1:0];

    always_comb begin
        value_d    = value_q;
        step_sel_d = step_sel_q;
        streak_d   = streak_q;
        dir_d      = dir_q;
        timer_d    = (timer_q == WIN_T) ? timer_q : timer_q + TW'(1);
        changed_d  = 1'b0;

        if (bus.keyEdge)
            step_sel_d = (step_sel_q == 2'd2) ? 2'd0 : step_sel_q + 2'd1;

        if (bus.clear) begin
            value_d   = MIN_W;
            streak_d  = 2'd0;
            dir_d     = DIR_NONE;
            timer_d   = '0;
            changed_d = (value_q != MIN_W);
        end else if (detent) begin
            value_d   = next_w;
            streak_d  = streak_det;
            dir_d     = dir_now;
            timer_d   = '0;
            changed_d = (next_w != value_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q    <= MIN_W;
            step_sel_q <= 2'd0;
            streak_q   <= 2'd0;
            timer_q    <= WIN_T;
            dir_q      <= DIR_NONE;
            changed_q  <= 1'b0;
        end else begin
            value_q    <= value_d;
            step_sel_q <= step_sel_d;
            streak_q   <= streak_d;
            timer_q    <= timer_d;
            dir_q      <= dir_d;
            changed_q  <= changed_d;
        end
    end

    assign bus.value   = value_q;
    assign bus.stepSel = step_sel_q;
    assign bus.changed = changed_q;
    assign bus.atLimit = (value_q == MIN_W) || (value_q == MAX_W);
endmodule
